register_file: RTL and testbench



---
 rtl/register_file.sv | 98 +++++++++
 tb/tb_register_file.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// RV32I integer register file: 2**ADDR_WIDTH x DATA_WIDTH, x0 hardwired to zero.
// Two combinational read ports and one synchronous write port.
//
// Ports
//   clk                 rising-edge clock
//   rst                 synchronous active-high reset; clears every register and
//                       takes priority over a write in the same cycle
//   wr_en/wr_reg/wr_data  write port, sampled at the rising edge; writes to x0 dropped
//   rd_reg_1/rd_reg_2   read addresses
//   rd_data_1/rd_data_2 read data, zero-latency, x0 always reads 0
//
// Build option
//   REG_FILE_BYPASS_EN  when defined, a write in flight (wr_en=1, rst=0, wr_reg!=0)
//                       is forwarded to any read port addressing the same register
//                       in the same cycle. Undefined: reads see the old value until
//                       the edge.

module register_file_rd_port #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic [2**ADDR_WIDTH-1:0][DATA_WIDTH-1:0] rf,
  input  logic [ADDR_WIDTH-1:0]                    rd_reg,
  input  logic                                     byp_vld,
  input  logic [ADDR_WIDTH-1:0]                    byp_reg,
  input  logic [DATA_WIDTH-1:0]                    byp_data,
  output logic [DATA_WIDTH-1:0]                    rd_data
);
  always_comb begin
    rd_data = rf[rd_reg];
    if (rd_reg == '0)                          rd_data = '0;
    else if (byp_vld && (rd_reg == byp_reg))   rd_data = byp_data;
  end
endmodule

module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_reg,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_reg_1,
  input  logic [ADDR_WIDTH-1:0] rd_reg_2,
  output logic [DATA_WIDTH-1:0] rd_data_1,
  output logic [DATA_WIDTH-1:0] rd_data_2
);
  localparam int NUM_REGS  = 2**ADDR_WIDTH;
  localparam int NUM_PORTS = 2;

  // x0 has no storage; registers 1..NUM_REGS-1 are flops.
  logic [DATA_WIDTH-1:0]                 mem [1:NUM_REGS-1];
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]   rf;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
    // Decoding i >= 1 against wr_reg means x0 writes match nothing.
    always_ff @(posedge clk) begin
      if (rst)                                       mem[i] <= '0;
      else if (wr_en && (wr_reg == ADDR_WIDTH'(i)))  mem[i] <= wr_data;
    end
  end

  always_comb begin
    rf[0] = '0;
    for (int i = 1; i < NUM_REGS; i++) rf[i] = mem[i];
  end

  logic byp_vld;
`ifdef REG_FILE_BYPASS_EN
  // Reset cycles never forward: the write is discarded, so its data must not leak.
  assign byp_vld = wr_en && !rst && (wr_reg != '0);
`else
  assign byp_vld = 1'b0;
`endif

  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] rd_regs;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rd_datas;

  assign rd_regs   = {rd_reg_2, rd_reg_1};
  assign rd_data_1 = rd_datas[0];
  assign rd_data_2 = rd_datas[1];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd
    register_file_rd_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_rd (
      .rf       (rf),
      .rd_reg   (rd_regs[p]),
      .byp_vld  (byp_vld),
      .byp_reg  (wr_reg),
      .byp_data (wr_data),
      .rd_data  (rd_datas[p])
    );
  end
endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file. The driver sets up read addresses and pushes
// the hand-computed expected data into a queue; the monitor drains the queue at
// each falling edge and compares against the live read ports.
module tb_register_file;
  logic        clk = 1'b0;
  logic        rst, wr_en;
  logic [4:0]  wr_reg, rd_reg_1, rd_reg_2;
  logic [31:0] wr_data, rd_data_1, rd_data_2;

  always #5 clk = ~clk;

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
    .rd_reg_1(rd_reg_1), .rd_reg_2(rd_reg_2),
    .rd_data_1(rd_data_1), .rd_data_2(rd_data_2)
  );

  typedef struct {
    string       name;
    int          port;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

`ifdef REG_FILE_BYPASS_EN
  localparam logic [31:0] RDW_EXP = 32'h2;
`else
  localparam logic [31:0] RDW_EXP = 32'h1;
`endif

  // Monitor: read ports are combinational, so every queued expectation is
  // compared mid-cycle, away from the active edge.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (q.size() > 0) begin
      e   = q.pop_front();
      act = (e.port == 2) ? rd_data_2 : rd_data_1;
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s port%0d: got %08h expected %08h", e.name, e.port, act, e.exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rd(input string name, input int port, input logic [31:0] exp);
    exp_t e;
    e.name = name; e.port = port; e.exp = exp;
    q.push_back(e);
  endtask

  task automatic wr(input logic [4:0] r, input logic [31:0] d);
    wr_en = 1'b1; wr_reg = r; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic sweep_zero(input string name);
    for (int a = 0; a < 32; a++) begin
      rd_reg_1 = 5'(a);
      rd_reg_2 = 5'(31 - a);
      expect_rd(name, 1, 32'h0);
      expect_rd(name, 2, 32'h0);
      step();
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_reg = '0; wr_data = '0;
    rd_reg_1 = '0; rd_reg_2 = '0;
    step();
    rst = 1'b0;

    // Reset state on all addresses, both ports.
    sweep_zero("reset_sweep");

    // Basic write / readback.
    wr(5'd5,  32'hDEADBEEF);
    wr(5'd31, 32'h12345678);
    rd_reg_1 = 5'd5; rd_reg_2 = 5'd31;
    expect_rd("wr_x5", 1, 32'hDEADBEEF);
    expect_rd("wr_x31", 2, 32'h12345678);
    step();

    // Same address on both ports.
    rd_reg_1 = 5'd31; rd_reg_2 = 5'd31;
    expect_rd("same_addr", 1, 32'h12345678);
    expect_rd("same_addr", 2, 32'h12345678);
    step();

    // A few more distinct patterns, overwrite included.
    wr(5'd1,  32'h0000_0001);
    wr(5'd16, 32'h8000_0000);
    wr(5'd5,  32'h0F0F_0F0F);
    rd_reg_1 = 5'd1; rd_reg_2 = 5'd16;
    expect_rd("wr_x1", 1, 32'h0000_0001);
    expect_rd("wr_x16", 2, 32'h8000_0000);
    step();
    rd_reg_1 = 5'd5; rd_reg_2 = 5'd2;
    expect_rd("overwrite_x5", 1, 32'h0F0F_0F0F);
    expect_rd("untouched_x2", 2, 32'h0);
    step();

    // x0 immutability, also while a write to x0 is in flight.
    wr_en = 1'b1; wr_reg = 5'd0; wr_data = 32'hFFFFFFFF;
    rd_reg_1 = 5'd0; rd_reg_2 = 5'd0;
    expect_rd("x0_during_wr", 1, 32'h0);
    expect_rd("x0_during_wr", 2, 32'h0);
    step();
    wr_en = 1'b0;
    expect_rd("x0_after_wr", 1, 32'h0);
    expect_rd("x0_after_wr", 2, 32'h0);
    step();

    // wr_en gating.
    wr(5'd7, 32'hA5A5A5A5);
    wr_en = 1'b0; wr_reg = 5'd7; wr_data = 32'h0;
    step();
    rd_reg_1 = 5'd7;
    expect_rd("wr_en_gate", 1, 32'hA5A5A5A5);
    step();

    // Read-during-write.
    wr(5'd3, 32'h1);
    wr_en = 1'b1; wr_reg = 5'd3; wr_data = 32'h2;
    rd_reg_1 = 5'd3; rd_reg_2 = 5'd7;
    expect_rd("rdw_before", 1, RDW_EXP);
    expect_rd("rdw_other_port", 2, 32'hA5A5A5A5);
    step();
    wr_en = 1'b0;
    expect_rd("rdw_after", 1, 32'h2);
    step();

    // Reset priority over a same-cycle write; pre-reset contents visible until the edge.
    wr(5'd9, 32'hCAFEF00D);
    rst = 1'b1; wr_en = 1'b1; wr_reg = 5'd9; wr_data = 32'h55;
    rd_reg_1 = 5'd9; rd_reg_2 = 5'd5;
    expect_rd("pre_reset_x9", 1, 32'hCAFEF00D);
    expect_rd("pre_reset_x5", 2, 32'h0F0F_0F0F);
    step();
    rst = 1'b0; wr_en = 1'b0;
    sweep_zero("post_reset_sweep");

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
